// File: rtl/dp_pkg.sv
// dp_pkg: state encoding and bit indices shared by the dot-product sequencer
package dp_pkg;
   typedef enum logic [2:0] {
      IDLE, REQ_A, RSP_A, REQ_B, RSP_B, ACC, WRITE, FINISH
   } state_t;
   localparam int BUSY      = 0;
   localparam int DONE      = 1;
   localparam int ERR       = 2;
   localparam int CTRL_EN   = 0;
   localparam int RES_BYTES = 4;
endpackage

// File: rtl/dp_mac.sv
// dp_mac: 32-bit wrapping accumulator of unsigned 8x8 products
module dp_mac (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [31:0] acc,
   output logic [31:0] acc_next
);
   logic [15:0] prod;
   assign prod     = a * b;
   assign acc_next = acc + {16'b0, prod};
   // clear on an accepted start, accumulate one product per ACC cycle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) acc <= '0;
      else if (clr) acc <= '0;
      else if (en) acc <= acc_next;
endmodule

// File: rtl/dp_sequencer.sv
// dp_sequencer: fetches A/B byte vectors, accumulates the dot product and writes it back
module dp_sequencer
   import dp_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int MAX_LEN = 1024
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic              start_signal,
   input  logic [31:0]       cfg_ctrl,
   input  logic [ADDR_W-1:0] cfg_a_base,
   input  logic [ADDR_W-1:0] cfg_b_base,
   input  logic [ADDR_W-1:0] cfg_out_addr,
   input  logic [31:0]       cfg_len,
   output logic [31:0]       status,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [7:0]        mem_req_wdata,
   input  logic              mem_rsp_valid,
   input  logic [7:0]        mem_rsp_rdata,
   output logic [7:0]        DP_A,
   output logic [7:0]        DP_B,
   output logic [31:0]       DP_RESULT
);
   state_t            state;
   logic              busy, done, err;
   logic [ADDR_W-1:0] a_base, b_base, out_addr;
   logic [31:0]       len, idx, idx_nx;
   logic [1:0]        wb, wb_nx;
   logic              start_ok;
   logic [31:0]       acc, acc_next;
   logic              unused_ctrl;
   assign unused_ctrl = ^cfg_ctrl;
   assign start_ok    = (state == IDLE) && start_signal && cfg_ctrl[CTRL_EN];
   assign idx_nx      = idx + 32'd1;
   assign wb_nx       = wb + 2'd1;
   assign DP_RESULT   = acc;
   dp_mac u_mac (
      .clk      (ACLK),
      .rst_n    (ARESETN),
      .clr      (start_ok),
      .en       (state == ACC),
      .a        (DP_A),
      .b        (DP_B),
      .acc      (acc),
      .acc_next (acc_next)
   );
   // status word assembled from the sticky/busy flags
   always_comb begin
      status       = '0;
      status[BUSY] = busy;
      status[DONE] = done;
      status[ERR]  = err;
   end
   // sequencer FSM; every memory-port field is loaded on entry to its request state
   always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) begin
         state         <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         DP_A          <= '0;
         DP_B          <= '0;
         a_base        <= '0;
         b_base        <= '0;
         out_addr      <= '0;
         len           <= '0;
         idx           <= '0;
         wb            <= '0;
      end else begin
         case (state)
            IDLE: if (start_ok) begin
               a_base   <= cfg_a_base;
               b_base   <= cfg_b_base;
               out_addr <= cfg_out_addr;
               len      <= cfg_len;
               idx      <= '0;
               wb       <= '0;
               if (cfg_len > 32'(MAX_LEN)) begin
                  err  <= 1'b1;
                  done <= 1'b1;
                  busy <= 1'b0;
               end else if (cfg_len == '0) begin
                  err           <= 1'b0;
                  done          <= 1'b0;
                  busy          <= 1'b1;
                  state         <= WRITE;
                  mem_req_valid <= 1'b1;
                  mem_req_we    <= 1'b1;
                  mem_req_addr  <= cfg_out_addr;
                  mem_req_wdata <= '0;
               end else begin
                  err           <= 1'b0;
                  done          <= 1'b0;
                  busy          <= 1'b1;
                  state         <= REQ_A;
                  mem_req_valid <= 1'b1;
                  mem_req_we    <= 1'b0;
                  mem_req_addr  <= cfg_a_base;
               end
            end
            REQ_A: if (mem_req_ready) begin
               mem_req_valid <= 1'b0;
               state         <= RSP_A;
            end
            RSP_A: if (mem_rsp_valid) begin
               DP_A          <= mem_rsp_rdata;
               mem_req_valid <= 1'b1;
               mem_req_addr  <= b_base + ADDR_W'(idx);
               state         <= REQ_B;
            end
            REQ_B: if (mem_req_ready) begin
               mem_req_valid <= 1'b0;
               state         <= RSP_B;
            end
            RSP_B: if (mem_rsp_valid) begin
               DP_B  <= mem_rsp_rdata;
               state <= ACC;
            end
            ACC: begin
               idx           <= idx_nx;
               mem_req_valid <= 1'b1;
               if (idx_nx == len) begin
                  state         <= WRITE;
                  mem_req_we    <= 1'b1;
                  mem_req_addr  <= out_addr;
                  mem_req_wdata <= acc_next[7:0];
                  wb            <= '0;
               end else begin
                  state        <= REQ_A;
                  mem_req_addr <= a_base + ADDR_W'(idx_nx);
               end
            end
            WRITE: if (mem_req_ready) begin
               if (wb == 2'(RES_BYTES - 1)) begin
                  mem_req_valid <= 1'b0;
                  mem_req_we    <= 1'b0;
                  state         <= FINISH;
               end else begin
                  wb            <= wb_nx;
                  mem_req_addr  <= mem_req_addr + ADDR_W'(1);
                  mem_req_wdata <= acc[{wb_nx, 3'b000} +: 8];
               end
            end
            FINISH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_dp_sequencer.sv
// tb_dp_sequencer: table-driven runs against a scoreboarded memory model
module tb_dp_sequencer;
   localparam int MAX_LEN = 1024;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [7:0]  data;
   } txn_t;

   typedef struct {
      logic [31:0] a_base;
      logic [31:0] b_base;
      logic [31:0] out;
      logic [31:0] len;
      logic [31:0] a_bytes;
      logic [31:0] b_bytes;
      logic [31:0] exp_res;
      logic [31:0] exp_status;
      bit          stall;
      int          extra_start;
   } vec_t;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic        start_signal = 1'b0;
   logic [31:0] cfg_ctrl = '0, cfg_a_base = '0, cfg_b_base = '0, cfg_out_addr = '0, cfg_len = '0;
   logic [31:0] status;
   logic        mem_req_valid, mem_req_we;
   logic        mem_req_ready = 1'b1;
   logic [31:0] mem_req_addr;
   logic [7:0]  mem_req_wdata;
   logic        mem_rsp_valid = 1'b0;
   logic [7:0]  mem_rsp_rdata = '0;
   logic [7:0]  DP_A, DP_B;
   logic [31:0] DP_RESULT;

   always #5 ACLK = ~ACLK;

   dp_sequencer #(.ADDR_W(32), .MAX_LEN(MAX_LEN)) dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .start_signal  (start_signal),
      .cfg_ctrl      (cfg_ctrl),
      .cfg_a_base    (cfg_a_base),
      .cfg_b_base    (cfg_b_base),
      .cfg_out_addr  (cfg_out_addr),
      .cfg_len       (cfg_len),
      .status        (status),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_we    (mem_req_we),
      .mem_req_addr  (mem_req_addr),
      .mem_req_wdata (mem_req_wdata),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_rdata (mem_rsp_rdata),
      .DP_A          (DP_A),
      .DP_B          (DP_B),
      .DP_RESULT     (DP_RESULT)
   );

   txn_t        sb[$];
   txn_t        e;
   logic [7:0]  mem [0:65535];
   int          checks = 0, fails = 0, n_req = 0, cnt = 0;
   bit          stall = 1'b0, pending = 1'b0, held = 1'b0;
   logic [31:0] pend_addr = '0, h_addr = '0;
   logic        h_we = 1'b0;
   logic [7:0]  h_wdata = '0;
   vec_t        vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model, evaluated on the falling edge: the values seen here are the
   // ones the DUT samples on the following rising edge.
   always @(negedge ACLK) begin
      if (!ARESETN) begin
         pending       = 1'b0;
         held          = 1'b0;
         mem_rsp_valid = 1'b0;
         mem_req_ready = 1'b1;
      end else begin
         if (mem_rsp_valid) begin
            mem_rsp_valid = 1'b0;
            pending       = 1'b0;
         end else if (pending) begin
            cnt--;
            if (cnt == 0) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_rdata = mem[pend_addr[15:0]];
            end
         end
         if (held) begin
            check("stall_addr", mem_req_addr, h_addr);
            check("stall_ctl", {22'b0, mem_req_valid, mem_req_we, mem_req_wdata}, {22'b0, 1'b1, h_we, h_wdata});
         end
         mem_req_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         held    = mem_req_valid && !mem_req_ready;
         h_addr  = mem_req_addr;
         h_we    = mem_req_we;
         h_wdata = mem_req_wdata;
         if (mem_req_valid && mem_req_ready) begin
            n_req++;
            check("one_outstanding", 32'(pending), 32'd0);
            if (sb.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_req: got we=%b addr=%h, expected no request", mem_req_we, mem_req_addr);
            end else begin
               e = sb.pop_front();
               check("req_we", 32'(mem_req_we), 32'(e.we));
               check("req_addr", mem_req_addr, e.addr);
               if (e.we) check("req_wdata", 32'(mem_req_wdata), 32'(e.data));
            end
            if (mem_req_we) mem[mem_req_addr[15:0]] = mem_req_wdata;
            else begin
               pending   = 1'b1;
               pend_addr = mem_req_addr;
               cnt       = stall ? int'($urandom_range(1, 5)) : 1;
            end
         end
      end
   end

   task automatic prep(input vec_t v);
      stall = v.stall;
      for (int k = 0; k < 4; k++) mem[16'(v.out + 32'(k))] = 8'hAA;
      for (int k = 0; k < 4; k++) begin
         mem[16'(v.a_base + 32'(k))] = v.a_bytes[8*k +: 8];
         mem[16'(v.b_base + 32'(k))] = v.b_bytes[8*k +: 8];
      end
      if (v.len <= 32'(MAX_LEN)) begin
         for (int i = 0; i < int'(v.len); i++) begin
            sb.push_back('{1'b0, v.a_base + 32'(i), 8'h00});
            sb.push_back('{1'b0, v.b_base + 32'(i), 8'h00});
         end
         for (int k = 0; k < 4; k++) sb.push_back('{1'b1, v.out + 32'(k), v.exp_res[8*k +: 8]});
      end
   endtask

   task automatic kick(input vec_t v);
      @(negedge ACLK);
      cfg_ctrl     = 32'h1;
      cfg_a_base   = v.a_base;
      cfg_b_base   = v.b_base;
      cfg_out_addr = v.out;
      cfg_len      = v.len;
      start_signal = 1'b1;
   endtask

   task automatic run_vec(input vec_t v);
      int          cyc, exp_cyc, req0;
      bit          busy_ok;
      logic [31:0] got;
      prep(v);
      req0    = n_req;
      exp_cyc = (v.len > 32'(MAX_LEN)) ? 1 : 1 + 5 * int'(v.len) + 5;
      busy_ok = 1'b1;
      cyc     = 0;
      kick(v);
      for (int c = 1; c <= 3000; c++) begin
         @(negedge ACLK);
         if (c == 1) begin
            start_signal = 1'b0;
            cfg_a_base   = $urandom;
            cfg_b_base   = $urandom;
            cfg_out_addr = $urandom;
            cfg_len      = $urandom_range(1, 8);
         end
         if (c == v.extra_start) start_signal = 1'b1;
         else if (c == v.extra_start + 1) start_signal = 1'b0;
         if (status[1]) begin
            cyc = c;
            break;
         end
         if (status !== 32'h1) busy_ok = 1'b0;
      end
      start_signal = 1'b0;
      check("done_seen", 32'(cyc != 0), 32'd1);
      if (!v.stall) check("done_cycle", cyc, exp_cyc);
      check("busy_during_run", 32'(busy_ok), 32'd1);
      check("status", status, v.exp_status);
      check("dp_result", DP_RESULT, v.exp_res);
      for (int k = 0; k < 4; k++) got[8*k +: 8] = mem[16'(v.out + 32'(k))];
      check("mem_result", got, (v.len > 32'(MAX_LEN)) ? 32'hAAAA_AAAA : v.exp_res);
      check("req_count", n_req - req0, (v.len > 32'(MAX_LEN)) ? 0 : 2 * int'(v.len) + 4);
      check("sb_empty", sb.size(), 0);
   endtask

   initial begin
      vecs[0] = '{32'h0000_0000, 32'h0000_0100, 32'h0000_1000, 32'd3,    32'h0003_0201, 32'h0006_0504, 32'h0000_0020, 32'h2, 1'b0, 0};
      vecs[1] = '{32'h0000_0300, 32'h0000_0400, 32'hFFFF_FFFE, 32'd4,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0003_F804, 32'h2, 1'b0, 0};
      vecs[2] = '{32'h0000_0000, 32'h0000_0100, 32'h0000_1000, 32'd3,    32'h0003_0201, 32'h0006_0504, 32'h0000_0020, 32'h2, 1'b1, 0};
      vecs[3] = '{32'h0000_0000, 32'h0000_0100, 32'h0000_1020, 32'd0,    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h2, 1'b0, 0};
      vecs[4] = '{32'h0000_0000, 32'h0000_0100, 32'h0000_1030, 32'd1025, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h6, 1'b0, 0};
      vecs[5] = '{32'hFFFF_FFFE, 32'h0000_0200, 32'h0000_1040, 32'd4,    32'h281E_140A, 32'hFF80_0703, 32'h0000_3782, 32'h2, 1'b1, 0};
      vecs[6] = '{32'h0000_0000, 32'h0000_0100, 32'h0000_1050, 32'd3,    32'h0003_0201, 32'h0006_0504, 32'h0000_0020, 32'h2, 1'b0, 7};
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

      #1;
      check("rst_status", status, 32'h0);
      check("rst_valid_we", {30'b0, mem_req_valid, mem_req_we}, 32'h0);
      check("rst_addr", mem_req_addr, 32'h0);
      check("rst_wdata_dp", {mem_req_wdata, DP_A, DP_B, 8'h00}, 32'h0);
      check("rst_result", DP_RESULT, 32'h0);
      repeat (3) @(negedge ACLK);
      ARESETN = 1'b1;

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      begin
         int req0;
         req0 = n_req;
         @(negedge ACLK);
         cfg_ctrl     = 32'hFFFF_FFFE;
         cfg_len      = 32'd3;
         start_signal = 1'b1;
         @(negedge ACLK);
         start_signal = 1'b0;
         repeat (10) @(negedge ACLK);
         check("en0_status", status, 32'h2);
         check("en0_result", DP_RESULT, 32'h20);
         check("en0_no_req", n_req - req0, 0);
      end

      prep(vecs[0]);
      kick(vecs[0]);
      @(negedge ACLK);
      start_signal = 1'b0;
      repeat (7) @(negedge ACLK);
      ARESETN = 1'b0;
      #1;
      check("midrst_status", status, 32'h0);
      check("midrst_valid_we", {30'b0, mem_req_valid, mem_req_we}, 32'h0);
      check("midrst_addr", mem_req_addr, 32'h0);
      check("midrst_wdata_dp", {mem_req_wdata, DP_A, DP_B, 8'h00}, 32'h0);
      check("midrst_result", DP_RESULT, 32'h0);
      repeat (3) @(negedge ACLK);
      check("midrst_quiet", 32'(mem_req_valid), 32'd0);
      sb.delete();
      ARESETN = 1'b1;
      run_vec(vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/dp_sequencer.md
# dp_sequencer

Control sequencer for the AXI dot-product accelerator. It takes the configuration register values (control, vector A base, vector B base, length, output address), fetches byte elements of A and B over a single-outstanding memory request port, and accumulates their products. It then writes the 32-bit result back to memory little-endian and reports busy/done/error status. It sits between the register block and the system memory, and drives the DP_A/DP_B/DP_RESULT observation outputs.

## Interface
- ADDR_W, 32: memory byte-address width.
- MAX_LEN, 1024: largest legal vector length; larger lengths are errors.
- ACLK  input  1  clock, all logic rising-edge.
- ARESETN  input  1  asynchronous, active-low reset.
- start_signal  input  1  one-cycle start pulse.
- cfg_ctrl  input  32  bit0 = enable; other bits ignored.
- cfg_a_base / cfg_b_base / cfg_out_addr  input  ADDR_W  byte addresses.
- cfg_len  input  32  element count.
- status  output  32  bit0 busy, bit1 done (sticky), bit2 error (sticky); others 0.
- mem_req_valid  output  1  request valid.
- mem_req_ready  input  1  memory accepts request.
- mem_req_we  output  1  1 = write, 0 = read.
- mem_req_addr  output  ADDR_W  byte address.
- mem_req_wdata  output  8  write byte.
- mem_rsp_valid  input  1  read data valid.
- mem_rsp_rdata  input  8  read data.
- DP_A, DP_B  output  8  last fetched A/B element.
- DP_RESULT  output  32  running/final accumulator.

## Operation
- States: IDLE, REQ_A, RSP_A, REQ_B, RSP_B, ACC, WRITE, FINISH.
- IDLE, start_signal=1, enable=1:
  - Latch all cfg_* inputs.
  - Clear the accumulator, element index, done and error.
  - Set busy.
- Start handling outside that case:
  - If the latched length > MAX_LEN: set error and done, clear busy, return to IDLE with no memory traffic.
  - If length = 0: go directly to WRITE, which writes the value 0.
  - Otherwise go to REQ_A.
  - start_signal is ignored when enable=0 or when not in IDLE.
- Per element i:
  - REQ_A issues a read of a_base+i and holds until the handshake.
  - RSP_A waits for mem_rsp_valid and captures DP_A.
  - REQ_B and RSP_B do the same at b_base+i and capture DP_B.
  - ACC adds DP_A*DP_B (unsigned 8x8 → 16-bit, zero-extended) to the accumulator, wrapping mod 2^32.
  - ACC then increments i, going to WRITE if i+1 = len, else back to REQ_A.
- WRITE issues 4 byte writes to out_addr+0..3 in order, with data acc[7:0], acc[15:8], acc[23:16], acc[31:24]. Each write completes on the valid&ready handshake; writes have no response.
- FINISH: set done, clear busy, go to IDLE.
- Address arithmetic is mod 2^ADDR_W.

## Timing
- Reset values:
  - State IDLE.
  - status = 0.
  - mem_req_valid = 0, mem_req_we = 0.
  - mem_req_addr = 0, mem_req_wdata = 0.
  - DP_A = DP_B = 0, DP_RESULT = 0.
- All outputs are registered.
- Handshake rules:
  - mem_req_valid asserts the cycle after entry into a REQ or WRITE state.
  - Address, we and wdata stay stable until mem_req_ready is sampled high.
  - Valid never drops without a handshake.
  - One transaction is outstanding at most.
  - mem_rsp_valid is accepted only in RSP_A/RSP_B and ignored elsewhere.
  - The response arrives ≥1 cycle after its request handshake.
- Zero-wait memory (ready=1, response one cycle later):
  - 5 cycles per element, 4 cycles for the write-back, 1 cycle for FINISH.
  - Start (cycle 0) → done high at cycle 1 + 5·len + 4 + 1.
- Busy is high from the cycle after start through FINISH. Done rises the same edge busy falls.
- DP_RESULT updates in the cycle after ACC and holds after completion until the next accepted start.
- ARESETN asserted mid-operation returns everything immediately to reset values. An in-flight request is abandoned and no further writes are issued.

## Structure
- Package dp_pkg holds:
  - The state encoding.
  - Status bit indices (BUSY=0, DONE=1, ERR=2).
  - The ctrl enable bit index.
  - The result byte count (4).
- One sub-module, dp_mac: the 32-bit accumulator with clear and add-product enable, and an unsigned 8x8 multiplier. dp_sequencer holds the FSM, address generation and write-back mux.

## Test plan
- A=[01,02,03] at 0x0000, B=[04,05,06] at 0x0100, len=3, out=0x1000, zero-wait memory:
  - Required: mem[0x1000..0x1003] = 20 00 00 00 and DP_RESULT = 0x00000020.
  - Done at cycle 21, status = 0x2.
- len=4, all elements FF → result 0x0003F804, bytes 04 F8 03 00.
- Random mem_req_ready stalls and response delay of 1–5 cycles, same vectors as the first scenario:
  - Required: identical result.
  - Request fields stable while stalled.
  - Never more than one outstanding request.
- Length edge cases:
  - len=0 → 4 writes of 00, done with no reads.
  - len=MAX_LEN+1 → error|done (0x6), no memory requests.
- enable=0 with a start pulse → no activity. A start pulse while busy → ignored, result unchanged.
- ARESETN pulsed low during element 2 → all outputs at reset values. A following start completes the first scenario normally.
